// File: rtl/path_raster.sv
// path_raster: sequential polyline rasteriser. Optionally clears the framebuffer,
// draws Bresenham segments between consecutive points, then stamps a dot on each point.
module path_raster #(
    parameter int CW      = 8,
    parameter int NPTS    = 64,
    parameter int COLOR_W = 16,
    localparam int AW     = $clog2(NPTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear_en,
    input  logic               closed,
    input  logic [AW:0]        npts,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic [COLOR_W-1:0] line_color,
    input  logic [COLOR_W-1:0] dot_color,
    output logic [AW-1:0]      pt_addr,
    input  logic [CW-1:0]      pt_x,
    input  logic [CW-1:0]      pt_y,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [CW-1:0]      px_x,
    output logic [CW-1:0]      px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               busy,
    output logic               done
);
    localparam int SW = CW + 2;

    typedef enum logic [3:0] {IDLE, CLEAR, SEGA, SEGB, SETUP, LINE, DOTA, DOTB, DONE} state_t;
    state_t state_reg, state_next;

    logic [AW:0]          npts_reg, nseg_reg, k_reg, j_reg, nseg_calc, k_inc, j_inc;
    logic [COLOR_W-1:0]   bg_reg, line_reg, dot_reg;
    logic [AW-1:0]        pt_addr_reg;
    logic [CW-1:0]        cx_reg, cy_reg, x_reg, y_reg, bx_reg, by_reg;
    logic signed [SW-1:0] dx_reg, dy_reg, err_reg;
    logic                 sx_neg_reg, sy_neg_reg, busy_reg, done_reg;

    logic                 clear_last, line_end, no_pts, no_seg, step_x, step_y;
    logic signed [SW-1:0] ddx, ddy, adx, ady, err_step;
    logic signed [SW:0]   e2;

    assign k_inc      = k_reg + 1'b1;
    assign j_inc      = j_reg + 1'b1;
    assign clear_last = (&cx_reg) && (&cy_reg);
    assign line_end   = (x_reg == bx_reg) && (y_reg == by_reg);
    assign no_pts     = (npts_reg == '0);
    assign no_seg     = (nseg_reg == '0);

    // A closed path only adds the wrap-around segment when there is a real segment to close.
    always_comb begin
        nseg_calc = '0;
        if (npts > {{AW{1'b0}}, 1'b1})
            nseg_calc = npts - 1'b1 + {{AW{1'b0}}, closed};
    end

    // Segment setup: A is already in x_reg/y_reg, B is on the point bus.
    assign ddx = $signed({2'b00, pt_x}) - $signed({2'b00, x_reg});
    assign ddy = $signed({2'b00, pt_y}) - $signed({2'b00, y_reg});
    assign adx = ddx[SW-1] ? -ddx : ddx;
    assign ady = ddy[SW-1] ? -ddy : ddy;

    assign e2     = {err_reg, 1'b0};
    assign step_x = (e2 >= $signed({dy_reg[SW-1], dy_reg}));
    assign step_y = (e2 <= $signed({dx_reg[SW-1], dx_reg}));

    always_comb begin
        err_step = err_reg;
        if (step_x) err_step = err_step + dy_reg;
        if (step_y) err_step = err_step + dx_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = clear_en ? CLEAR : SEGA;
            CLEAR: if (px_ready && clear_last)
                       state_next = no_pts ? DONE : (no_seg ? DOTA : SEGA);
            SEGA:  state_next = no_pts ? DONE : (no_seg ? DOTA : SEGB);
            SEGB:  state_next = SETUP;
            SETUP: state_next = LINE;
            LINE:  if (px_ready && line_end) state_next = (k_inc < nseg_reg) ? SEGA : DOTA;
            DOTA:  state_next = DOTB;
            DOTB:  if (px_ready) state_next = (j_inc < npts_reg) ? DOTA : DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            npts_reg    <= '0;
            nseg_reg    <= '0;
            k_reg       <= '0;
            j_reg       <= '0;
            bg_reg      <= '0;
            line_reg    <= '0;
            dot_reg     <= '0;
            pt_addr_reg <= '0;
            cx_reg      <= '0;
            cy_reg      <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            bx_reg      <= '0;
            by_reg      <= '0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            err_reg     <= '0;
            sx_neg_reg  <= 1'b0;
            sy_neg_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: if (start) begin
                    npts_reg    <= npts;
                    nseg_reg    <= nseg_calc;
                    bg_reg      <= bg_color;
                    line_reg    <= line_color;
                    dot_reg     <= dot_color;
                    k_reg       <= '0;
                    j_reg       <= '0;
                    cx_reg      <= '0;
                    cy_reg      <= '0;
                    pt_addr_reg <= '0;
                end
                CLEAR: if (px_ready) begin
                    cx_reg <= cx_reg + 1'b1;
                    if (&cx_reg) cy_reg <= cy_reg + 1'b1;
                end
                SEGA: begin
                    if (state_next == SEGB)
                        pt_addr_reg <= (k_inc == npts_reg) ? '0 : k_inc[AW-1:0];
                    else
                        pt_addr_reg <= '0;
                end
                SEGB: begin
                    x_reg <= pt_x;
                    y_reg <= pt_y;
                end
                SETUP: begin
                    bx_reg     <= pt_x;
                    by_reg     <= pt_y;
                    dx_reg     <= adx;
                    dy_reg     <= -ady;
                    err_reg    <= adx - ady;
                    sx_neg_reg <= ddx[SW-1];
                    sy_neg_reg <= ddy[SW-1];
                end
                LINE: if (px_ready) begin
                    if (line_end) begin
                        k_reg       <= k_inc;
                        pt_addr_reg <= (state_next == SEGA) ? k_inc[AW-1:0] : '0;
                    end else begin
                        err_reg <= err_step;
                        if (step_x) x_reg <= sx_neg_reg ? x_reg - 1'b1 : x_reg + 1'b1;
                        if (step_y) y_reg <= sy_neg_reg ? y_reg - 1'b1 : y_reg + 1'b1;
                    end
                end
                DOTB: if (px_ready) begin
                    j_reg       <= j_inc;
                    pt_addr_reg <= j_inc[AW-1:0];
                end
                default: ;
            endcase
        end
    end

    assign px_valid = (state_reg == CLEAR) || (state_reg == LINE) || (state_reg == DOTB);
    assign pt_addr  = pt_addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    always_comb begin
        px_x     = '0;
        px_y     = '0;
        px_color = '0;
        case (state_reg)
            CLEAR: begin px_x = cx_reg; px_y = cy_reg; px_color = bg_reg;   end
            LINE:  begin px_x = x_reg;  px_y = y_reg;  px_color = line_reg; end
            DOTB:  begin px_x = pt_x;   px_y = pt_y;   px_color = dot_reg;  end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_path_raster.sv
// Bench for path_raster: directed and random frames against a textbook Bresenham model.
`timescale 1ns/1ps
module tb_path_raster;
    localparam int CW      = 4;
    localparam int NPTS    = 8;
    localparam int COLOR_W = 16;
    localparam int AW      = $clog2(NPTS);
    localparam int PW      = 2 * CW + COLOR_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               clear_en = 1'b0;
    logic               closed = 1'b0;
    logic [AW:0]        npts = '0;
    logic [COLOR_W-1:0] bg_color = '0, line_color = '0, dot_color = '0;
    logic [AW-1:0]      pt_addr;
    logic [CW-1:0]      pt_x, pt_y;
    logic               px_valid;
    logic               px_ready = 1'b0;
    logic [CW-1:0]      px_x, px_y;
    logic [COLOR_W-1:0] px_color;
    logic               busy, done;

    path_raster #(.CW(CW), .NPTS(NPTS), .COLOR_W(COLOR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .clear_en(clear_en), .closed(closed),
        .npts(npts), .bg_color(bg_color), .line_color(line_color), .dot_color(dot_color),
        .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y), .px_valid(px_valid),
        .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Point memory with one cycle of read latency.
    logic [CW-1:0] mem_x [NPTS];
    logic [CW-1:0] mem_y [NPTS];
    always @(posedge clk) begin
        pt_x <= mem_x[pt_addr];
        pt_y <= mem_y[pt_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int dir_x[6] = '{0, 0, 1, 1, 2, 2};
    int dir_y[6] = '{0, 1, 2, 3, 4, 5};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int x, input int y, input logic [COLOR_W-1:0] c);
        return {CW'(x), CW'(y), c};
    endfunction

    task automatic set_pt(input int i, input int x, input int y);
        mem_x[i] = CW'(x);
        mem_y[i] = CW'(y);
    endtask

    task automatic set_colors();
        bg_color   = COLOR_W'($urandom);
        line_color = COLOR_W'($urandom);
        dot_color  = COLOR_W'($urandom);
    endtask

    // Expected pixel stream: clear raster, each segment by textbook Bresenham, then dots.
    task automatic build_model(input bit clr, input bit cl, input int n);
        int nseg, b, x0, y0, x1, y1, dx, dy, sx, sy, err, e2;
        exp_q.delete();
        if (clr)
            for (int yy = 0; yy < (1 << CW); yy++)
                for (int xx = 0; xx < (1 << CW); xx++)
                    exp_q.push_back(pix(xx, yy, bg_color));
        nseg = (n >= 2) ? n - 1 + int'(cl) : 0;
        for (int s = 0; s < nseg; s++) begin
            b  = (s + 1) % n;
            x0 = int'(mem_x[s]); y0 = int'(mem_y[s]);
            x1 = int'(mem_x[b]); y1 = int'(mem_y[b]);
            dx = (x1 > x0) ? x1 - x0 : x0 - x1;
            dy = (y1 > y0) ? y0 - y1 : y1 - y0;
            sx = (x0 < x1) ? 1 : -1;
            sy = (y0 < y1) ? 1 : -1;
            err = dx + dy;
            for (int g = 0; g < 4 * (1 << CW); g++) begin
                exp_q.push_back(pix(x0, y0, line_color));
                if (x0 == x1 && y0 == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x0 += sx; end
                if (e2 <= dx) begin err += dx; y0 += sy; end
            end
        end
        for (int j = 0; j < n; j++)
            exp_q.push_back(pix(int'(mem_x[j]), int'(mem_y[j]), dot_color));
    endtask

    task automatic run_frame(input string tag, input bit clr, input bit cl, input int n,
                             input bit rnd, input bit inject);
        int done_t, done_cnt, last_fire, stall_bad, busy_bad;
        bit prev_stall;
        logic [PW-1:0] cur, prev_pix;
        done_t = -1; done_cnt = 0; last_fire = -1; stall_bad = 0; busy_bad = 0;
        prev_stall = 1'b0; prev_pix = '0;
        got_q.delete();
        @(negedge clk);
        clear_en = clr; closed = cl; npts = (AW+1)'(n); start = 1'b1;
        px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int t = 1; t <= 4000; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && t == 6) begin
                start = 1'b1; npts = (AW+1)'(1); clear_en = ~clr;
            end
            px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {px_x, px_y, px_color};
            if (prev_stall && (!px_valid || cur !== prev_pix)) stall_bad++;
            if (!busy && done_t < 0) busy_bad++;
            if (done_t >= 0 && t == done_t + 1 && busy) busy_bad++;
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (px_valid && px_ready) begin
                got_q.push_back(cur);
                last_fire = t;
            end
            prev_stall = px_valid && !px_ready;
            prev_pix   = cur;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(done_t >= 0), 64'd1);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_time"}, 64'(done_t), (exp_q.size() > 0) ? 64'(last_fire + 1) : 64'd2);
        check({tag, "_stall_stable"}, 64'(stall_bad), 64'd0);
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_px%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        $display("frame %s: npts=%0d clear=%0d closed=%0d pixels=%0d done_t=%0d",
                 tag, n, clr, cl, got_q.size(), done_t);
    endtask

    task automatic build_directed();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(pix(dir_x[i], dir_y[i], line_color));
        exp_q.push_back(pix(0, 0, dot_color));
        exp_q.push_back(pix(2, 5, dot_color));
    endtask

    initial begin
        int fires, bad_done, bad_valid, n;
        bit clr, cl;
        for (int i = 0; i < NPTS; i++) set_pt(i, 0, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_px_valid", 64'(px_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pt_addr", 64'(pt_addr), 64'd0);
        check("rst_px_x", 64'(px_x), 64'd0);
        check("rst_px_y", 64'(px_y), 64'd0);
        check("rst_px_color", 64'(px_color), 64'd0);

        set_colors();
        build_model(1'b1, 1'b0, 0);
        run_frame("clear_only", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("clear_only_total", 64'(got_q.size()), 64'd256);

        set_colors();
        set_pt(0, 0, 0); set_pt(1, 2, 5);
        build_directed();
        run_frame("two_pt", 1'b0, 1'b0, 2, 1'b0, 1'b0);

        set_colors();
        set_pt(0, 2, 3); set_pt(1, 6, 3); set_pt(2, 6, 7);
        build_model(1'b0, 1'b1, 3);
        check("closed_model_len", 64'(exp_q.size()), 64'd18);
        run_frame("closed_inject", 1'b0, 1'b1, 3, 1'b0, 1'b1);
        run_frame("closed_stall", 1'b0, 1'b1, 3, 1'b1, 1'b0);

        set_pt(0, 9, 9);
        build_model(1'b0, 1'b0, 1);
        run_frame("single_dot", 1'b0, 1'b0, 1, 1'b0, 1'b0);
        check("single_dot_total", 64'(got_q.size()), 64'd1);

        set_pt(0, 5, 7); set_pt(1, 5, 7);
        build_model(1'b0, 1'b0, 2);
        run_frame("degenerate", 1'b0, 1'b0, 2, 1'b0, 1'b0);
        check("degenerate_total", 64'(got_q.size()), 64'd3);

        build_model(1'b0, 1'b0, 0);
        run_frame("empty", 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Abort mid-line, then confirm the engine restarts cleanly.
        set_pt(0, 0, 0); set_pt(1, 2, 5);
        @(negedge clk);
        clear_en = 1'b0; closed = 1'b0; npts = (AW+1)'(2); start = 1'b1; px_ready = 1'b1;
        fires = 0;
        for (int t = 0; t < 50 && fires < 3; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (px_valid && px_ready) fires++;
        end
        check("abort_fires", 64'(fires), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_px_valid", 64'(px_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        bad_done = 0; bad_valid = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (done) bad_done++;
            if (px_valid) bad_valid++;
        end
        check("abort_no_done", 64'(bad_done), 64'd0);
        check("abort_idle", 64'(bad_valid), 64'd0);
        set_colors();
        build_directed();
        run_frame("after_abort", 1'b0, 1'b0, 2, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(0, NPTS);
            clr = (r == 2);
            cl  = 1'($urandom_range(0, 1));
            for (int i = 0; i < NPTS; i++)
                set_pt(i, $urandom_range(0, (1 << CW) - 1), $urandom_range(0, (1 << CW) - 1));
            set_colors();
            build_model(clr, cl, n);
            run_frame($sformatf("rand%0d", r), clr, cl, n, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/path_raster.md
# path_raster

Parametrised polyline rasteriser for the path-visualisation display. It reads an ordered list of path points from a synchronous point memory and can first clear the framebuffer. It then draws every segment between consecutive points with Bresenham stepping and finally stamps a dot on each point. Pixels leave through a valid/ready write port into the framebuffer writer, one pixel per cycle when not back-pressured. It replaces per-pixel combinational segment testing with a sequential, width-independent engine.

## Interface
- CW, 8: coordinate width; framebuffer is 2^CW x 2^CW.
- NPTS, 64: maximum path points; AW = clog2(NPTS) derived.
- COLOR_W, 16: pixel colour width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a frame; accepted only in IDLE.
- clear_en  in  1  sampled with start: 1 = clear the framebuffer before drawing.
- closed  in  1  sampled with start: 1 = add segment P[npts-1] -> P[0].
- npts  in  AW+1  number of valid points, 0..NPTS; sampled with start.
- bg_color, line_color, dot_color  in  COLOR_W  each; sampled with start.
- pt_addr  out  AW  point index to read.
- pt_x, pt_y  in  CW  point at pt_addr, valid exactly 1 cycle after pt_addr.
- px_valid  out  1  pixel write request.
- px_ready  in  1  framebuffer accepts the pixel.
- px_x, px_y  out  CW  pixel coordinate.
- px_color  out  COLOR_W  pixel colour.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, CLEAR, SEGA, SEGB, SETUP, LINE, DOTA, DOTB, DONE.
- IDLE: start=1 latches the sampled inputs and moves to CLEAR if clear_en, else to SEGA. start in any other state is ignored.
- Segment count: nseg = npts-1 when npts>=2, plus 1 when closed and npts>=2. With npts<=1, nseg = 0.
- Skip rules: when nseg = 0, go straight to DOTA; when npts = 0, go straight to DONE.
- CLEAR: emits bg_color for every pixel in raster order (y outer, x inner, both 0..2^CW-1), then moves on.
- SEGA: pt_addr = k, where k is the segment index.
- SEGB: captures A = P[k]; sets pt_addr = (k+1 == npts) ? 0 : k+1.
- SETUP: captures B and computes:
  - dx = |xB-xA|, dy = -|yB-yA|, err = dx+dy;
  - sx, sy = +1 / -1 step directions;
  - (x, y) = A.
- Arithmetic is signed, CW+2 bits; e2 = 2*err in CW+3 bits; no overflow is possible for any coordinate pair.
- LINE: px = (x, y) with line_color. On each accepted pixel (px_valid and px_ready):
  - if (x, y) == B, the segment ends: k+1 < nseg -> SEGA, else -> DOTA;
  - otherwise, with e2 = 2*err: if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy. Both updates may apply in the same step.
- Both endpoints are drawn. A shared vertex is written twice. A degenerate segment (A == B) emits exactly one pixel.
- DOTA / DOTB: for j = 0..npts-1, DOTA issues pt_addr = j and DOTB emits P[j] with dot_color. Dots overwrite lines.
- DONE: done = 1 for one cycle, then IDLE.

## Timing
- Reset values: px_valid=0, busy=0, done=0, pt_addr=0, px_x=0, px_y=0, px_color=0. State is IDLE and all counters are 0.
- rst mid-frame: state returns to IDLE on the next edge and px_valid drops; no done is produced. Any pixel not yet accepted is lost.
- busy = 1 from the cycle after start is accepted through the DONE cycle inclusive.
- Backpressure: while px_valid=1 and px_ready=0, px_x, px_y and px_color hold stable and no state advances. px_valid never drops without a handshake, except on rst.
- Throughput: 1 pixel/cycle in CLEAR and LINE when px_ready is held at 1.
- Overhead: 3 cycles per segment (SEGA, SEGB, SETUP); dots take 2 cycles each.
- done asserts the cycle after the final accepted pixel. With no pixels at all (npts=0, clear_en=0), done asserts 2 cycles after start.
- pt_addr is registered. Capture happens in the cycle after the address is presented, i.e. 1-cycle memory latency exactly.

## Test plan
- Reset, then idle with start=0 → all outputs hold their reset values. start pulses during busy → ignored, and the frame completes unchanged.
- CW=4, clear_en=1, npts=0, px_ready=1 → 256 bg_color pixels (0,0),(1,0)..(15,15), done the next cycle, done high for exactly 1 cycle.
- npts=2, P0=(0,0), P1=(2,5), clear_en=0 → line pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), then dots (0,0),(2,5) in dot_color.
- closed=1, npts=3, points (2,3),(6,3),(6,7) → segment 2 draws (6,7)→(2,3) diagonally, 5 pixels, followed by 3 dots.
- Same stimulus as the previous item with px_ready toggling randomly (about 50%) → accepted pixel sequence identical to px_ready=1, and outputs stable throughout every stall.
- npts=1 at (9,9) → exactly one dot. npts=2 with identical points → segment of 1 pixel plus 2 dots. rst asserted mid-LINE → px_valid=0 the next cycle, no done, and a new start runs a clean frame.
